// File: rtl/alu_entry_pkg.sv
// Shared types and constants for the ALU operand-entry front end.
// State encodings are visible on LEDR, so they are fixed explicitly.
package alu_entry_pkg;

  typedef enum logic [2:0] {
    GET_A = 3'd0,
    GET_B = 3'd1,
    GET_F = 3'd2,
    ISSUE = 3'd3,
    SHOW  = 3'd4
  } state_t;

  // Function codes understood by the lab ALU; 6 and 7 are passed through and yield 0.
  localparam logic [2:0] FN_INC     = 3'd0;
  localparam logic [2:0] FN_ADD     = 3'd1;
  localparam logic [2:0] FN_ADD_BEH = 3'd2;
  localparam logic [2:0] FN_XOR_OR  = 3'd3;
  localparam logic [2:0] FN_REDOR   = 3'd4;
  localparam logic [2:0] FN_CONCAT  = 3'd5;

  localparam logic [7:0] ERR_RESULT = 8'hEE;

endpackage

// File: rtl/alu_operand_entry_key_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stability counter and
// a one-cycle press pulse on the debounced rising edge (releases are silent).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          level, level_prev;
  logic [CW-1:0] count;

  // NOTE: every flop here is sequential state, so only non-blocking assignments are used.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      count      <= '0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      level_prev <= level;
      if (sync2 == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        // Input has differed for the full window: accept the new level.
        level <= sync2;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign press = level & ~level_prev;

endmodule

// File: rtl/alu_operand_entry.sv
// Button-driven operand/function entry for the lab ALU: collects A, B and F,
// issues one req/ack transaction with timeout and holds the result for display.
module alu_operand_entry
  import alu_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       enter,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_func,
  output logic       alu_req,
  input  logic       alu_ack,
  input  logic [7:0] alu_result,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       error,
  output logic [2:0] state_code
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic       press;
  state_t     state_q, state_d;
  logic [3:0] a_d, b_d;
  logic [2:0] f_d;
  logic [7:0] res_d;
  logic       err_q, err_d;
  logic [7:0] tcnt_q, tcnt_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clock(clock),
    .reset(reset),
    .raw  (enter),
    .press(press)
  );

  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = alu_a;
    b_d     = alu_b;
    f_d     = alu_func;
    res_d   = result;
    err_d   = err_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      GET_A: if (press) begin a_d = sw; state_d = GET_B; end
      GET_B: if (press) begin b_d = sw; state_d = GET_F; end
      GET_F: if (press) begin
        f_d     = sw[2:0];
        tcnt_d  = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        // Ack has priority over a timeout landing in the same cycle.
        if (alu_ack) begin
          res_d   = alu_result;
          err_d   = 1'b0;
          state_d = SHOW;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          res_d   = ERR_RESULT;
          err_d   = 1'b1;
          state_d = SHOW;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      SHOW:    if (press) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= GET_A;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_func <= '0;
      result   <= '0;
      err_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      alu_a    <= a_d;
      alu_b    <= b_d;
      alu_func <= f_d;
      result   <= res_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign alu_req      = (state_q == ISSUE);
  assign result_valid = (state_q == SHOW);
  assign error        = err_q & (state_q == SHOW);
  assign state_code   = state_q;

endmodule
